// File: rtl/disp_hex_mux_n.sv
// -----------------------------------------------------------------------------
// disp_hex_mux_n
// Parametrised N-digit multiplexed seven-segment driver. It scans DIGITS hex
// digits through time-shared anode enables. Display data lives in shadow
// registers, which are reloaded only at a frame boundary through an
// upd_req/upd_ack handshake. The driver also provides per-digit blanking,
// leading-zero suppression and PWM brightness control.
//
// Parameters
//   DIGITS  number of digits scanned (2..16)
//   DIV_W   prescaler width; each digit slot lasts 2**DIV_W clk cycles
//   PWM_W   brightness resolution (PWM_W <= DIV_W)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   lamp_test  (only with DISP_LAMP_TEST_EN) light every segment of the scanned digit
//   hex_in     digit i = hex_in[4i+3:4i]; digit 0 is the rightmost digit
//   dp_in      decimal point per digit
//   blank_in   1 = digit fully dark
//   lz_en      leading-zero suppression enable (live)
//   bright     brightness level (live)
//   upd_req    request to load hex_in/dp_in/blank_in into the shadow registers
//   upd_ack    1-cycle pulse after the shadow registers were loaded
//   an         one-hot digit enable, active high
//   sseg       [6:0] = abcdefg active low (a = bit 6), [7] = dp active high
//
// Configuration macro: DISP_LAMP_TEST_EN adds the lamp_test input.
// -----------------------------------------------------------------------------
module disp_hex_mux_n #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16,
  parameter int PWM_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
`ifdef DISP_LAMP_TEST_EN
  input  logic                lamp_test,
`endif
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lz_en,
  input  logic [PWM_W-1:0]    bright,
  input  logic                upd_req,
  output logic                upd_ack,
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          sseg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    prescaler_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] hex_sh_q;
  logic [DIGITS-1:0]   dp_sh_q;
  logic [DIGITS-1:0]   blank_sh_q;
  logic                upd_ack_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          sseg_q, sseg_d;

  logic                tick;
  logic                load;
  logic [PWM_W-1:0]    phase;
  logic                pwm_on;
  logic [DIGITS-1:0]   supp;
  logic                lamp;

`ifdef DISP_LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  assign tick   = (prescaler_q == '1);
  // The shadow registers are loaded only on the last cycle of the last slot,
  // so the new data always becomes visible on a whole frame.
  assign load   = tick && (idx_q == LAST_IDX) && upd_req;
  assign phase  = prescaler_q[DIV_W-1 -: PWM_W];
  assign pwm_on = (bright == '1) || (phase < bright);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h01;  4'h1: decode = 7'h4F;
      4'h2: decode = 7'h12;  4'h3: decode = 7'h06;
      4'h4: decode = 7'h4C;  4'h5: decode = 7'h24;
      4'h6: decode = 7'h20;  4'h7: decode = 7'h0F;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h04;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h60;
      4'hC: decode = 7'h31;  4'hD: decode = 7'h42;
      4'hE: decode = 7'h30;  default: decode = 7'h38;
    endcase
  endfunction

  // Walking down from the most significant digit, a digit is suppressed
  // while every digit from it upwards is zero. Digit 0 is never suppressed.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (hex_sh_q[4*i +: 4] == 4'h0);
      supp[i]  = lz_en && (i != 0) && zero_run;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    an_d   = '0;
    sseg_d = 8'h7F;
    if (lamp) begin
      an_d[idx_q] = 1'b1;
      sseg_d      = 8'h80;
    end else if (!blank_sh_q[idx_q] && pwm_on) begin
      an_d[idx_q] = 1'b1;
      sseg_d[7]   = dp_sh_q[idx_q];
      if (!supp[idx_q]) sseg_d[6:0] = decode(hex_sh_q[4*idx_q +: 4]);
    end
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      hex_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '1;
      upd_ack_q   <= 1'b0;
      an_q        <= '0;
      sseg_q      <= 8'h7F;
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
      if (tick) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      upd_ack_q <= load;
      if (load) begin
        hex_sh_q   <= hex_in;
        dp_sh_q    <= dp_in;
        blank_sh_q <= blank_in;
      end
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign upd_ack = upd_ack_q;
  assign an      = an_q;
  assign sseg    = sseg_q;

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// -----------------------------------------------------------------------------
// tb_disp_hex_mux_n
// Scoreboard bench for disp_hex_mux_n (DIGITS=4, DIV_W=4, PWM_W=2). A reference
// model counts cycles since reset and derives the expected slot, digit and PWM
// phase arithmetically. On every clock it pushes the expected {upd_ack, an, sseg}
// into a queue. A monitor on the falling edge pops each entry and compares it
// with the DUT outputs. Directed phases follow the test plan; randomized
// updates come after them.
// -----------------------------------------------------------------------------
module tb_disp_hex_mux_n;

  localparam int DIGITS = 4;
  localparam int DIV_W  = 4;
  localparam int PWM_W  = 2;
  localparam int SLOT   = 1 << DIV_W;
  localparam int FRAME  = SLOT * DIGITS;

  logic                clk = 1'b0;
  logic                reset;
  logic                lamp;
  logic [4*DIGITS-1:0] hex_in;
  logic [DIGITS-1:0]   dp_in, blank_in;
  logic                lz_en;
  logic [PWM_W-1:0]    bright;
  logic                upd_req;
  logic                upd_ack;
  logic [DIGITS-1:0]   an;
  logic [7:0]          sseg;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int on_cnt = 0;

  always #5 clk = ~clk;

  disp_hex_mux_n #(.DIGITS(DIGITS), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef DISP_LAMP_TEST_EN
    .lamp_test(lamp),
`endif
    .hex_in   (hex_in),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .lz_en    (lz_en),
    .bright   (bright),
    .upd_req  (upd_req),
    .upd_ack  (upd_ack),
    .an       (an),
    .sseg     (sseg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  int                  m_t = 0;
  logic [4*DIGITS-1:0] m_hex;
  logic [DIGITS-1:0]   m_dp, m_blank;
  logic [31:0]         exp_q [$];

  // Expected {an, sseg} for the state described by cycle count t.
  function automatic logic [31:0] model_disp(input int t);
    int   slot, dig, phase, val;
    logic lit, sup;
    logic [DIGITS-1:0] a;
    logic [7:0] s;
    slot  = t % SLOT;
    dig   = (t / SLOT) % DIGITS;
    phase = slot / (SLOT >> PWM_W);
    lit   = (int'(bright) == (1 << PWM_W) - 1) || (phase < int'(bright));
    a     = '0;
    s     = 8'h7F;
    if (lamp) begin
      a[dig] = 1'b1;
      s      = 8'h80;
    end else if (!m_blank[dig] && lit) begin
      a[dig] = 1'b1;
      val    = int'((m_hex >> (4 * dig)) & 16'hF);
      sup    = lz_en && (dig > 0) && ((m_hex >> (4 * dig)) == 0);
      s      = {m_dp[dig], sup ? 7'h7F : seg_tab[val]};
    end
    return 32'({a, s});
  endfunction

  always @(posedge clk) begin
    logic [31:0] e;
    logic        ack;
    if (reset) begin
      m_t     = 0;
      m_hex   = '0;
      m_dp    = '0;
      m_blank = '1;
      exp_q.push_back(32'({1'b0, {DIGITS{1'b0}}, 8'h7F}));
    end else begin
      e   = model_disp(m_t);
      ack = ((m_t % FRAME) == FRAME - 1) && upd_req;
      exp_q.push_back(e | (32'(ack) << (DIGITS + 8)));
      if (ack) begin
        m_hex   = hex_in;
        m_dp    = dp_in;
        m_blank = blank_in;
      end
      m_t++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'({upd_ack, an, sseg}), e);
      if (upd_ack === 1'b1) ack_cnt++;
      if (an !== '0) on_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present data with upd_req and hold it until the ack appears.
  task automatic do_update(input logic [4*DIGITS-1:0] h, input logic [DIGITS-1:0] d,
                           input logic [DIGITS-1:0] b);
    bit seen = 0;
    @(negedge clk);
    hex_in   = h;
    dp_in    = d;
    blank_in = b;
    upd_req  = 1'b1;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (upd_ack === 1'b1) seen = 1;
    end
    upd_req = 1'b0;
    check("ack_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    int a0;
    reset = 1'b1; lamp = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
    lz_en = 1'b0; bright = 2'd3; upd_req = 1'b0;

    // 1. reset then idle: dark display, no acks
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(200);
    check("idle_acks", 32'(ack_cnt), 32'd0);

    // 2. first update, full brightness
    a0 = ack_cnt;
    do_update(16'h1234, 4'h0, 4'h0);
    wait_cycles(FRAME + 3);
    check("single_ack", 32'(ack_cnt - a0), 32'd1);

    // 3. leading-zero suppression
    lz_en = 1'b1;
    do_update(16'h0007, 4'h0, 4'h0);
    wait_cycles(FRAME);
    do_update(16'h0000, 4'h2, 4'h0);
    wait_cycles(FRAME);

    // 4. brightness: bright=1 lights 4 cycles per slot, bright=0 none
    lz_en = 1'b0;
    do_update(16'h5678, 4'h0, 4'h0);
    bright = 2'd1;
    wait_cycles(2);
    on_cnt = 0;
    wait_cycles(FRAME);
    check("bright1_on_cycles", 32'(on_cnt), 32'(FRAME / 4));
    bright = 2'd0;
    wait_cycles(2);
    on_cnt = 0;
    wait_cycles(FRAME);
    check("bright0_on_cycles", 32'(on_cnt), 32'd0);
    bright = 2'd3;

    // 5. input change without request, then reset mid-handshake
    do_update(16'hABCD, 4'h5, 4'h0);
    wait_cycles(20);
    hex_in = 16'h9999; dp_in = 4'hF;
    wait_cycles(2 * FRAME);
    for (int i = 0; i < FRAME && (m_t % FRAME) != 20; i++) @(negedge clk);
    a0 = ack_cnt;
    upd_req = 1'b1;
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    upd_req = 1'b0;
    wait_cycles(FRAME + 5);
    check("no_ack_after_reset", 32'(ack_cnt - a0), 32'd0);

`ifdef DISP_LAMP_TEST_EN
    // 6. lamp test overrides blanking
    do_update(16'h1234, 4'h0, 4'hF);
    lamp = 1'b1;
    wait_cycles(FRAME + 2);
    lamp = 1'b0;
`endif

    // randomized updates and live controls
    for (int k = 0; k < 20; k++) begin
      lz_en  = 1'($urandom);
      bright = PWM_W'($urandom);
`ifdef DISP_LAMP_TEST_EN
      lamp   = ($urandom_range(0, 3) == 0);
`endif
      do_update(16'($urandom & (($urandom_range(0, 1) == 1) ? 32'h00FF : 32'hFFFF)),
                4'($urandom), 4'($urandom_range(0, 2) == 0 ? $urandom : 0));
      wait_cycles($urandom_range(0, 100));
    end

    wait_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
